// File: rtl/cordic_pkg.sv
// cordic_pkg: shared widths, arctangent table and FSM states for the iterative CORDIC vectoring controller
package cordic_pkg;
  localparam int DW = 14;
  localparam int AW = 16;
  localparam logic signed [AW-1:0] HALF_PI = 16'sd6434;
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
  // Padded to 16 entries so any 4-bit shift index is a legal lookup
  localparam logic signed [AW-1:0] ATAN [16] = '{
    16'sd3217, 16'sd1899, 16'sd1003, 16'sd509, 16'sd256, 16'sd128, 16'sd64, 16'sd32,
    16'sd16, 16'sd8, 16'sd4, 16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0
  };
endpackage

// File: rtl/cordic_vec_ctrl_if.sv
// cordic_vec_ctrl_if: sample-in and result-out handshake channels of the CORDIC vectoring controller
interface cordic_vec_ctrl_if;
  logic                              in_valid;
  logic                              in_ready;
  logic signed [cordic_pkg::DW-1:0]  x_in;
  logic signed [cordic_pkg::DW-1:0]  y_in;
  logic                              out_valid;
  logic                              out_ready;
  logic signed [cordic_pkg::AW-1:0]  mag_out;
  logic signed [cordic_pkg::AW-1:0]  phase_out;
  modport master (output in_valid, x_in, y_in, out_ready, input in_ready, out_valid, mag_out, phase_out);
  modport slave  (input in_valid, x_in, y_in, out_ready, output in_ready, out_valid, mag_out, phase_out);
endinterface

// File: rtl/cordic_vec_step.sv
// cordic_vec_step: one combinational vectoring micro-rotation with a runtime shift amount
module cordic_vec_step
  import cordic_pkg::*;
(
  input  logic signed [AW-1:0] i_x,
  input  logic signed [AW-1:0] i_y,
  input  logic signed [AW-1:0] i_z,
  input  logic signed [AW-1:0] i_atan,
  input  logic        [3:0]    i_shift,
  output logic signed [AW-1:0] o_x,
  output logic signed [AW-1:0] o_y,
  output logic signed [AW-1:0] o_z
);
  logic signed [AW-1:0] w_xs, w_ys;
  logic                 w_neg;
  assign w_xs  = i_x >>> i_shift;
  assign w_ys  = i_y >>> i_shift;
  assign w_neg = i_y[AW-1];
  assign o_x   = w_neg ? i_x - w_ys : i_x + w_ys;
  assign o_y   = w_neg ? i_y + w_xs : i_y - w_xs;
  assign o_z   = w_neg ? i_z - i_atan : i_z + i_atan;
endmodule

// File: rtl/cordic_vec_ctrl.sv
// cordic_vec_ctrl: iterative CORDIC vectoring, one shared micro-rotation reused for ITER cycles
module cordic_vec_ctrl
  import cordic_pkg::*;
#(
  parameter int ITER = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  cordic_vec_ctrl_if.slave  io_bus
);
  state_t               r_state, w_next;
  logic [3:0]           r_i;
  logic signed [AW-1:0] r_x, r_y, r_z;
  logic signed [AW-1:0] w_x, w_y, w_z;
  logic signed [AW-1:0] w_xin, w_yin, w_x0, w_y0, w_z0;
  logic                 w_accept;
  assign w_xin = {{(AW-DW){io_bus.x_in[DW-1]}}, io_bus.x_in};
  assign w_yin = {{(AW-DW){io_bus.y_in[DW-1]}}, io_bus.y_in};
  // Left-half-plane samples are turned by +/-90 degrees so the micro-rotations only cover +/-99 degrees
  assign w_x0 = !w_xin[AW-1] ? w_xin : !w_yin[AW-1] ? w_yin : -w_yin;
  assign w_y0 = !w_xin[AW-1] ? w_yin : !w_yin[AW-1] ? -w_xin : w_xin;
  assign w_z0 = !w_xin[AW-1] ? '0 : !w_yin[AW-1] ? HALF_PI : -HALF_PI;
  assign w_accept = (r_state == IDLE) && io_bus.in_valid;
  cordic_vec_step u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_atan  (ATAN[r_i]),
    .i_shift (r_i),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_z     (w_z)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = io_bus.in_valid ? ROT : IDLE;
      ROT:     w_next = (r_i == 4'(ITER-1)) ? DONE : ROT;
      DONE:    w_next = io_bus.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i <= '0;
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
    end else if (w_accept) begin
      r_i <= '0;
      r_x <= w_x0;
      r_y <= w_y0;
      r_z <= w_z0;
    end else if (r_state == ROT) begin
      r_i <= r_i + 4'd1;
      r_x <= w_x;
      r_y <= w_y;
      r_z <= w_z;
    end
  end
  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_valid = (r_state == DONE);
  assign io_bus.mag_out   = r_x;
  assign io_bus.phase_out = r_z;
endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// tb_cordic_vec_ctrl: directed vectors with hand-derived magnitude/phase expectations
module tb_cordic_vec_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mg_q[$];
  int   ph_q[$];
  cordic_vec_ctrl_if bus();
  cordic_vec_ctrl #(.ITER(12)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      mg_q.push_back(int'(bus.mag_out));
      ph_q.push_back(int'(bus.phase_out));
    end
  end
  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((obs - exp <= tol) && (exp - obs <= tol))
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask
  task automatic send(input int x, input int y, input bit keep);
    @(negedge clk);
    bus.x_in = 14'(x);
    bus.y_in = 14'(y);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 40 && bus.in_ready !== 1'b1; t++) @(negedge clk);
    @(posedge clk);
    #1 bus.in_valid = keep;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic take();
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask
  task automatic vec(input string tag, input int x, input int y, input int emag, input int mtol, input int eph);
    int lat;
    send(x, y, 1'b0);
    wait_out(lat);
    chk({tag, "_mag"}, int'(bus.mag_out), emag, mtol);
    chk({tag, "_phase"}, int'(bus.phase_out), eph, 4);
    take();
  endtask
  initial begin
    int lat, m0, p0, n;
    longint acc_t[3];
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    #2;
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_in_ready", int'(bus.in_ready), 1, 0);
    chk("rst_mag", int'(bus.mag_out), 0, 0);
    chk("rst_phase", int'(bus.phase_out), 0, 0);
    @(negedge clk) rst_n = 1'b1;
    send(4096, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrot_out_valid", int'(bus.out_valid), 0, 0);
    chk("midrot_in_ready", int'(bus.in_ready), 1, 0);
    chk("midrot_mag", int'(bus.mag_out), 0, 0);
    @(negedge clk) rst_n = 1'b1;
    send(4096, 0, 1'b0);
    chk("busy_in_ready", int'(bus.in_ready), 0, 0);
    wait_out(lat);
    chk("latency", lat, 12, 0);
    chk("p0_mag", int'(bus.mag_out), 6745, 8);
    chk("p0_phase", int'(bus.phase_out), 0, 4);
    take();
    vec("p90", 0, 4096, 6745, 8, 6434);
    vec("p180", -4096, 0, 6745, 8, 12868);
    vec("m180", -4096, -1, 6745, 8, -12868);
    send(-4096, -4096, 1'b0);
    wait_out(lat);
    m0 = int'(bus.mag_out);
    p0 = int'(bus.phase_out);
    chk("m135_mag", m0, 9539, 12);
    chk("m135_phase", p0, -9651, 4);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(bus.out_valid), 1, 0);
      chk("hold_mag", int'(bus.mag_out), m0, 0);
      chk("hold_phase", int'(bus.phase_out), p0, 0);
      chk("hold_in_ready", int'(bus.in_ready), 0, 0);
    end
    take();
    chk("post_hs_valid", int'(bus.out_valid), 0, 0);
    chk("post_hs_in_ready", int'(bus.in_ready), 1, 0);
    mg_q.delete();
    ph_q.delete();
    @(negedge clk) bus.out_ready = 1'b1;
    send(4096, 0, 1'b1);
    acc_t[0] = $time;
    send(0, 4096, 1'b1);
    acc_t[1] = $time;
    send(-4096, -4096, 1'b1);
    acc_t[2] = $time;
    bus.in_valid = 1'b0;
    n = 0;
    while (ph_q.size() < 3 && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    chk("b2b_count", ph_q.size(), 3, 0);
    chk("b2b_gap0", int'(acc_t[1] - acc_t[0]), 140, 0);
    chk("b2b_gap1", int'(acc_t[2] - acc_t[1]), 140, 0);
    if (ph_q.size() == 3) begin
      chk("b2b_ph0", ph_q[0], 0, 4);
      chk("b2b_ph1", ph_q[1], 6434, 4);
      chk("b2b_ph2", ph_q[2], -9651, 4);
      chk("b2b_mg0", mg_q[0], 6745, 8);
      chk("b2b_mg2", mg_q[2], 9539, 12);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
